store_buffer: RTL and testbench

- Data-side memory-stage block between the pipelined core's M-stage memory port and a multi-cycle data memory with a req/ack handshake.
- Queues stores in a DEPTH-entry FIFO and drains them to memory in the background.
- Forwards buffered store data to loads with a matching word address.
- Raises StallM when the core must wait: buffer full on a store, or a load miss being serviced by memory.

---
 rtl/store_buffer.sv | 140 ++++++++++++++
 tb/tb_store_buffer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer between the M-stage memory port and a req/ack data memory; forwards buffered stores to loads.
// Latency: forwarding hits are combinational; misses stall through LOAD and release in LDONE; drains run in the background.
// Backpressure: StallM on a store into a full buffer or on a load miss; memory requests are held until mem_ack.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       MemWriteM,
    input  logic                       MemReadM,
    input  logic [AW-1:0]              ALUOutM,
    input  logic [DW-1:0]              WriteDataM,
    output logic [DW-1:0]              ReadDataM,
    output logic                       StallM,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [AW-1:0]              mem_addr,
    output logic [DW-1:0]              mem_wdata,
    input  logic                       mem_ack,
    input  logic [DW-1:0]              mem_rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;
    localparam logic [1:0] LDONE = 2'd3;

    logic [1:0]    state;
    logic [AW-1:0] addrQ [DEPTH];
    logic [DW-1:0] dataQ [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [DW-1:0] loadReg;

    logic          full;
    logic          accept;
    logic          drainAck;
    logic          loadReq;
    logic          hit;
    logic          loadMiss;
    logic [DW-1:0] hitData;
    logic [PW-1:0] idx;

    assign full     = (count == CW'(DEPTH));
    assign accept   = MemWriteM && !full;
    assign drainAck = (state == DRAIN) && mem_ack;
    assign loadReq  = MemReadM && !MemWriteM;
    assign loadMiss = loadReq && !hit;
    assign empty    = (count == '0);

    // Walk from oldest to youngest so the last match is the youngest store.
    always_comb begin
        hit     = 1'b0;
        hitData = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if ((CW'(k) < count) && (addrQ[idx][AW-1:2] == ALUOutM[AW-1:2])) begin
                hit     = 1'b1;
                hitData = dataQ[idx];
            end
        end
    end

    assign StallM    = (MemWriteM && full) || (loadMiss && (state != LDONE));
    assign ReadDataM = (loadReq && hit && (state != LDONE)) ? hitData : loadReg;

    always_ff @(posedge clk) begin
        if (accept) begin
            addrQ[tail] <= ALUOutM;
            dataQ[tail] <= WriteDataM;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (accept)
                tail <= tail + PW'(1);
            if (drainAck)
                head <= head + PW'(1);
            case ({accept, drainAck})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            loadReg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (loadMiss) begin
                        state    <= LOAD;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= ALUOutM;
                    end else if (count != '0) begin
                        state     <= DRAIN;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= addrQ[head];
                        mem_wdata <= dataQ[head];
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                LOAD: begin
                    if (mem_ack) begin
                        loadReg <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= LDONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed stimulus for store_buffer; expected memory transactions and load results are queued and checked by a monitor.
module tb_store_buffer;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } memTxn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM;
    logic        MemReadM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        empty;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    memTxn_t     memQ[$];
    logic [31:0] loadQ[$];
    memTxn_t     monT;
    logic [31:0] monD;

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .MemWriteM(MemWriteM), .MemReadM(MemReadM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .StallM(StallM),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory handshakes and released loads are checked against the queues.
    always @(negedge clk) begin
        if (reset) begin
            if (mem_req && mem_ack) begin
                if (memQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_unexpected: got addr %h we %b expected no request", mem_addr, mem_we);
                end else begin
                    monT = memQ.pop_front();
                    chk("mem_we", {31'd0, mem_we}, {31'd0, monT.we});
                    chk("mem_addr", mem_addr, monT.addr);
                    if (monT.we)
                        chk("mem_wdata", mem_wdata, monT.data);
                end
            end
            if (MemReadM && !MemWriteM && !StallM) begin
                if (loadQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL load_unexpected: got %h expected no load", ReadDataM);
                end else begin
                    monD = loadQ.pop_front();
                    chk("ReadDataM", ReadDataM, monD);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic waitReq;
        for (int i = 0; i < 20 && !mem_req; i++)
            tick();
        if (!mem_req) begin
            checks++;
            errors++;
            $display("FAIL wait_req: got mem_req 0 expected 1 within 20 cycles");
        end
    endtask

    task automatic ackAfter(input int n, input logic [31:0] rd);
        waitReq();
        repeat (n) tick();
        mem_ack   = 1'b1;
        mem_rdata = rd;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWriteM  = 1'b1;
        ALUOutM    = a;
        WriteDataM = d;
        memQ.push_back('{1'b1, a, d});
        @(negedge clk);
        chk("store_stall", {31'd0, StallM}, 32'd0);
        tick();
        MemWriteM = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        MemWriteM  = 1'b0;
        MemReadM   = 1'b0;
        ALUOutM    = '0;
        WriteDataM = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;

        @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_stall", {31'd0, StallM}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_rdata", ReadDataM, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Two stores drain in order.
        store(32'h100, 32'h11);
        store(32'h104, 32'h22);
        ackAfter(2, 32'h0);
        ackAfter(2, 32'h0);
        repeat (2) tick();
        chk("t1_empty", {31'd0, empty}, 32'd1);
        chk("t1_count", {29'd0, count}, 32'd0);

        // Fill the buffer; a fifth store stalls, ignores a same-cycle ack, then enters.
        for (int i = 0; i < 4; i++)
            store(32'h500 + 32'(4 * i), 32'h50 + 32'(i));
        MemWriteM  = 1'b1;
        ALUOutM    = 32'h510;
        WriteDataM = 32'h54;
        memQ.push_back('{1'b1, 32'h510, 32'h54});
        mem_ack    = 1'b1;
        @(negedge clk);
        chk("t2_full_stall", {31'd0, StallM}, 32'd1);
        chk("t2_full_count", {29'd0, count}, 32'd4);
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("t2_after_ack_count", {29'd0, count}, 32'd3);
        chk("t2_after_ack_stall", {31'd0, StallM}, 32'd0);
        tick();
        MemWriteM = 1'b0;
        @(negedge clk);
        chk("t2_refill_count", {29'd0, count}, 32'd4);
        for (int i = 0; i < 4; i++)
            ackAfter(1, 32'h0);
        repeat (2) tick();
        chk("t2_empty", {31'd0, empty}, 32'd1);

        // Forwarding from the youngest matching store, with a drain outstanding.
        store(32'h200, 32'hAA);
        store(32'h200, 32'hBB);
        MemReadM = 1'b1;
        ALUOutM  = 32'h203;
        loadQ.push_back(32'hBB);
        @(negedge clk);
        chk("t3_hit_stall", {31'd0, StallM}, 32'd0);
        chk("t3_no_read_we", {31'd0, mem_we}, 32'd1);
        chk("t3_drain_addr", mem_addr, 32'h200);
        tick();
        MemReadM = 1'b0;
        ackAfter(1, 32'h0);
        ackAfter(1, 32'h0);
        repeat (2) tick();

        // Load miss with the buffer empty.
        MemReadM = 1'b1;
        ALUOutM  = 32'h300;
        memQ.push_back('{1'b0, 32'h300, 32'h0});
        loadQ.push_back(32'hDEAD);
        @(negedge clk);
        chk("t4_miss_stall", {31'd0, StallM}, 32'd1);
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t4_wait_stall", {31'd0, StallM}, 32'd1);
            chk("t4_wait_we", {31'd0, mem_we}, 32'd0);
            chk("t4_wait_req", {31'd0, mem_req}, 32'd1);
            tick();
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD;
        @(negedge clk);
        chk("t4_ack_stall", {31'd0, StallM}, 32'd1);
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("t4_ldone_stall", {31'd0, StallM}, 32'd0);
        tick();
        MemReadM = 1'b0;
        @(negedge clk);
        chk("t4_hold_rdata", ReadDataM, 32'hDEAD);
        tick();

        // Load miss during a drain waits for the drain ack plus one idle cycle.
        store(32'h600, 32'h77);
        waitReq();
        MemReadM = 1'b1;
        ALUOutM  = 32'h400;
        memQ.push_back('{1'b0, 32'h400, 32'h0});
        loadQ.push_back(32'h4444);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t5_stall", {31'd0, StallM}, 32'd1);
            chk("t5_hold_addr", mem_addr, 32'h600);
            chk("t5_hold_wdata", mem_wdata, 32'h77);
            chk("t5_hold_we", {31'd0, mem_we}, 32'd1);
            tick();
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("t5_idle_gap_req", {31'd0, mem_req}, 32'd0);
        chk("t5_idle_gap_stall", {31'd0, StallM}, 32'd1);
        tick();
        @(negedge clk);
        chk("t5_read_req", {31'd0, mem_req}, 32'd1);
        chk("t5_read_we", {31'd0, mem_we}, 32'd0);
        chk("t5_read_addr", mem_addr, 32'h400);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h4444;
        tick();
        mem_ack = 1'b0;
        tick();
        MemReadM = 1'b0;
        tick();

        // Reset in the middle of a drain, then a stray ack.
        store(32'h700, 32'h1);
        store(32'h704, 32'h2);
        store(32'h708, 32'h3);
        waitReq();
        reset = 1'b0;
        #1;
        chk("t6_rst_req", {31'd0, mem_req}, 32'd0);
        chk("t6_rst_count", {29'd0, count}, 32'd0);
        chk("t6_rst_empty", {31'd0, empty}, 32'd1);
        memQ.delete();
        tick();
        reset = 1'b1;
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("t6_stray_count", {29'd0, count}, 32'd0);
        chk("t6_stray_req", {31'd0, mem_req}, 32'd0);
        tick();
        store(32'h800, 32'h88);
        ackAfter(1, 32'h0);
        repeat (2) tick();
        chk("t6_final_empty", {31'd0, empty}, 32'd1);

        chk("memQ_drained", memQ.size(), 32'd0);
        chk("loadQ_drained", loadQ.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
